// File: rtl/stopwatch_bcd_core.sv
// Prescaled tick generator and MM:SS BCD stopwatch with start/stop/clear button control.
// Define STOPWATCH_LAP_EN to add the lap_n display-freeze input.
module stopwatch_bcd_core #(
  parameter int PRESC_W     = 24,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic               start_stop,
  input  logic               clear,
`ifdef STOPWATCH_LAP_EN
  input  logic               lap_n,
`endif
  input  logic [PRESC_W-1:0] cmp_value,
  output logic               tick,
  output logic [3:0]         sec_ones,
  output logic [2:0]         sec_tens,
  output logic [3:0]         min_ones,
  output logic [2:0]         min_tens,
  output logic               running,
  output logic               digits_upd,
  output logic               rollover
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [PRESC_W-1:0]     presc_q, presc_d;
  logic [SYNC_STAGES-1:0] ss_sync_q, ss_sync_d;
  logic [SYNC_STAGES-1:0] clr_sync_q, clr_sync_d;
  logic                   ss_prev_q, ss_prev_d;
  // Packed count layout: {min_tens[2:0], min_ones[3:0], sec_tens[2:0], sec_ones[3:0]}
  logic [13:0]            cnt_q, cnt_d;
  logic [13:0]            disp_q, disp_d;
  logic                   tick_q, tick_d;
  logic                   roll_q, roll_d;
  logic                   upd_q, upd_d;
  logic                   run_q, run_d;

  logic ss_s;
  logic clr_s;
  logic ss_edge_s;
  logic tc_s;
  logic wrap_s;

`ifdef STOPWATCH_LAP_EN
  // Holds the inverted lap_n so that the cleared state means "lap released".
  logic [SYNC_STAGES-1:0] lap_sync_q, lap_sync_d;
  logic                   lap_s;

  assign lap_s = lap_sync_q[SYNC_STAGES-1];
`endif

  assign ss_s      = ss_sync_q[SYNC_STAGES-1];
  assign clr_s     = clr_sync_q[SYNC_STAGES-1];
  assign ss_edge_s = ss_s & ~ss_prev_q;

  // Returns {wrap, next_count}; out-of-range digits fall back to zero instead of sticking.
  function automatic logic [14:0] count_inc(input logic [13:0] c);
    logic [3:0] so;
    logic [2:0] st;
    logic [3:0] mo;
    logic [2:0] mt;
    logic       wrap;
    so   = c[3:0];
    st   = c[6:4];
    mo   = c[10:7];
    mt   = c[13:11];
    wrap = 1'b0;
    if (so >= 4'd9) begin
      so = 4'd0;
      if (st >= 3'd5) begin
        st = 3'd0;
        if (mo >= 4'd9) begin
          mo = 4'd0;
          if (mt >= 3'd5) begin
            mt   = 3'd0;
            wrap = 1'b1;
          end else begin
            mt = mt + 3'd1;
          end
        end else begin
          mo = mo + 4'd1;
        end
      end else begin
        st = st + 3'd1;
      end
    end else begin
      so = so + 4'd1;
    end
    return {wrap, mt, mo, st, so};
  endfunction

  // Control FSM, prescaler, live count and synchroniser shifting.
  always_comb begin
    state_d    = state_q;
    presc_d    = presc_q;
    cnt_d      = cnt_q;
    ss_sync_d  = ss_sync_q;
    clr_sync_d = clr_sync_q;
    ss_prev_d  = ss_prev_q;
    tc_s       = 1'b0;
    wrap_s     = 1'b0;
`ifdef STOPWATCH_LAP_EN
    lap_sync_d = lap_sync_q;
`endif
    if (ena) begin
      ss_sync_d  = {ss_sync_q[SYNC_STAGES-2:0], start_stop};
      clr_sync_d = {clr_sync_q[SYNC_STAGES-2:0], clear};
      ss_prev_d  = ss_s;
`ifdef STOPWATCH_LAP_EN
      lap_sync_d = {lap_sync_q[SYNC_STAGES-2:0], ~lap_n};
`endif
      if (clr_s) begin
        state_d = ST_IDLE;
        presc_d = '0;
        cnt_d   = 14'd0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            presc_d = '0;
            if (ss_edge_s) begin
              state_d = ST_RUN;
            end else begin
              state_d = ST_IDLE;
            end
          end
          ST_RUN: begin
            // >= so a lowered terminal count ticks at once rather than wrapping the counter.
            if (presc_q >= cmp_value) begin
              presc_d         = '0;
              tc_s            = 1'b1;
              {wrap_s, cnt_d} = count_inc(cnt_q);
            end else begin
              presc_d = presc_q + PRESC_W'(1);
            end
            if (ss_edge_s) begin
              state_d = ST_PAUSE;
            end else begin
              state_d = ST_RUN;
            end
          end
          ST_PAUSE: begin
            if (ss_edge_s) begin
              state_d = ST_RUN;
            end else begin
              state_d = ST_PAUSE;
            end
          end
          default: begin
            state_d = ST_IDLE;
            presc_d = '0;
            cnt_d   = 14'd0;
          end
        endcase
      end
    end else begin
      state_d = state_q;
      presc_d = presc_q;
      cnt_d   = cnt_q;
    end
  end

  // Display staging: digit outputs, change strobe and pulse outputs.
  always_comb begin
    disp_d = disp_q;
    upd_d  = 1'b0;
    tick_d = tc_s;
    roll_d = wrap_s;
    run_d  = (state_d == ST_RUN);
    if (ena) begin
`ifdef STOPWATCH_LAP_EN
      if (lap_s && !clr_s) begin
        disp_d = disp_q;
      end else begin
        disp_d = cnt_d;
      end
`else
      disp_d = cnt_d;
`endif
      upd_d = (disp_d != disp_q);
    end else begin
      disp_d = disp_q;
      upd_d  = 1'b0;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      presc_q    <= '0;
      ss_sync_q  <= '0;
      clr_sync_q <= '0;
      ss_prev_q  <= 1'b0;
      cnt_q      <= 14'd0;
      disp_q     <= 14'd0;
      tick_q     <= 1'b0;
      roll_q     <= 1'b0;
      upd_q      <= 1'b0;
      run_q      <= 1'b0;
`ifdef STOPWATCH_LAP_EN
      lap_sync_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      ss_sync_q  <= ss_sync_d;
      clr_sync_q <= clr_sync_d;
      ss_prev_q  <= ss_prev_d;
      cnt_q      <= cnt_d;
      disp_q     <= disp_d;
      tick_q     <= tick_d;
      roll_q     <= roll_d;
      upd_q      <= upd_d;
      run_q      <= run_d;
`ifdef STOPWATCH_LAP_EN
      lap_sync_q <= lap_sync_d;
`endif
    end
  end

  assign tick       = tick_q;
  assign rollover   = roll_q;
  assign digits_upd = upd_q;
  assign running    = run_q;
  assign sec_ones   = disp_q[3:0];
  assign sec_tens   = disp_q[6:4];
  assign min_ones   = disp_q[10:7];
  assign min_tens   = disp_q[13:11];

endmodule
